// File: rtl/cache_pkg.sv
// Shared widths and state encoding for the cache controller and cache array.
package cache_pkg;

    // Ceiling log2, used to derive field widths from sizes.
    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int ADDR_W      = 28;
    localparam int DATA_W      = 32;
    localparam int BLOCK_W     = 256;
    localparam int CACHE_BYTES = 65536;
    localparam int WORDS       = BLOCK_W / DATA_W;
    localparam int OFFSET_W    = log2(WORDS);
    localparam int INDEX_W     = log2(CACHE_BYTES / (BLOCK_W / 8));
    localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
    localparam int REPL_TAG_W  = 15;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL,
        UPDATE
    } state_e;

endpackage

// File: rtl/cache_controller_if.sv
// CPU, cache-array and DDR signal bundle; master is the controller side.
interface cache_controller_if
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int BLOCK_SIZE = BLOCK_W
);
    // CPU load/store port
    logic [ADDR_WIDTH-1:0]   cpu_addr;
    logic                    cpu_rd;
    logic                    cpu_wr;
    logic [DATA_WIDTH-1:0]   cpu_wdata;
    logic [DATA_WIDTH-1:0]   cpu_rdata;
    logic                    cpu_ready;
    logic                    cpu_busy;
    // Cache array port
    logic [ADDR_WIDTH-1:0]   cache_addr;
    logic [BLOCK_SIZE-1:0]   cache_data_write;
    logic                    cache_dirty_write;
    logic                    cache_write_en;
    logic [BLOCK_SIZE-1:0]   cache_data_read;
    logic                    cache_dirty_read;
    logic                    cache_hit;
    logic [REPL_TAG_W-1:0]   cache_replace_tag;
    // DDR block port
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_rd_req;
    logic                    mem_wr_req;
    logic [BLOCK_SIZE-1:0]   mem_wdata;
    logic [BLOCK_SIZE-1:0]   mem_rdata;
    logic                    mem_ack;

    modport master (
        input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_busy,
        output cache_addr, cache_data_write, cache_dirty_write, cache_write_en,
        input  cache_data_read, cache_dirty_read, cache_hit, cache_replace_tag,
        output mem_addr, mem_rd_req, mem_wr_req, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output cpu_addr, cpu_rd, cpu_wr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_busy,
        input  cache_addr, cache_data_write, cache_dirty_write, cache_write_en,
        output cache_data_read, cache_dirty_read, cache_hit, cache_replace_tag,
        input  mem_addr, mem_rd_req, mem_wr_req, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/cache_controller.sv
// Write-back, write-allocate sequencer for a direct-mapped cache array.
// One request in flight: lookup, optional eviction, optional refill, array update.
module cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int BLOCK_SIZE = BLOCK_W,
    parameter int CACHE_SIZE = CACHE_BYTES
) (
    input  logic                clk,
    input  logic                rst_n,
    cache_controller_if.master  bus
);
    localparam int NWORDS = BLOCK_SIZE / DATA_WIDTH;
    localparam int OFF_W  = log2(NWORDS);
    localparam int IDX_W  = log2(CACHE_SIZE / (BLOCK_SIZE / 8));
    localparam int TG_W   = ADDR_WIDTH - IDX_W - OFF_W;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    wr_q, wr_d;
    logic [BLOCK_SIZE-1:0]   line_q, line_d;
    logic [BLOCK_SIZE-1:0]   evict_q, evict_d;
    logic [ADDR_WIDTH-1:0]   evict_addr_q, evict_addr_d;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic [OFF_W-1:0]        offset;
    logic [IDX_W-1:0]        index;
    logic [BLOCK_SIZE-1:0]   merged;
    logic [DATA_WIDTH-1:0]   hit_word, upd_word, rd_word;
    logic                    ready, write_en, rd_req, wr_req;
    logic [ADDR_WIDTH-1:0]   mem_addr_c;
    logic                    unused_repl_msb;

    assign offset   = addr_q[OFF_W-1:0];
    assign index    = addr_q[OFF_W +: IDX_W];
    assign hit_word = bus.cache_data_read[int'(offset)*DATA_WIDTH +: DATA_WIDTH];
    assign upd_word = merged[int'(offset)*DATA_WIDTH +: DATA_WIDTH];
    // The array reports a wider tag field than this geometry needs.
    assign unused_repl_msb = bus.cache_replace_tag[REPL_TAG_W-1];

    // Block written back to the array: line buffer with the store word merged in.
    always_comb begin
        merged = line_q;
        if (wr_q) merged[int'(offset)*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
    end

    // Next-state and per-state output decode.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        line_d       = line_q;
        evict_d      = evict_q;
        evict_addr_d = evict_addr_q;
        ready        = 1'b0;
        write_en     = 1'b0;
        rd_req       = 1'b0;
        wr_req       = 1'b0;
        mem_addr_c   = '0;
        rd_word      = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.cpu_wr || bus.cpu_rd) begin
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    wr_d    = bus.cpu_wr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.cache_hit) begin
                    if (wr_q) begin
                        line_d  = bus.cache_data_read;
                        state_d = UPDATE;
                    end else begin
                        ready   = 1'b1;
                        rd_word = hit_word;
                        state_d = IDLE;
                    end
                end else if (bus.cache_dirty_read) begin
                    evict_d      = bus.cache_data_read;
                    evict_addr_d = {bus.cache_replace_tag[TG_W-1:0], index, {OFF_W{1'b0}}};
                    state_d      = WRITEBACK;
                end else begin
                    state_d = FILL;
                end
            end
            WRITEBACK: begin
                wr_req     = 1'b1;
                mem_addr_c = evict_addr_q;
                if (bus.mem_ack) state_d = FILL;
            end
            FILL: begin
                rd_req     = 1'b1;
                mem_addr_c = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                if (bus.mem_ack) begin
                    line_d  = bus.mem_rdata;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                write_en = 1'b1;
                ready    = 1'b1;
                rd_word  = upd_word;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request, buffers and held load data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            line_q       <= '0;
            evict_q      <= '0;
            evict_addr_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            line_q       <= line_d;
            evict_q      <= evict_d;
            evict_addr_q <= evict_addr_d;
            if (ready) rdata_q <= rd_word;
        end
    end

    assign bus.cpu_ready         = ready;
    assign bus.cpu_rdata         = ready ? rd_word : rdata_q;
    assign bus.cpu_busy          = (state_q != IDLE);
    assign bus.cache_addr        = addr_q;
    assign bus.cache_data_write  = merged;
    assign bus.cache_dirty_write = wr_q;
    assign bus.cache_write_en    = write_en;
    assign bus.mem_addr          = mem_addr_c;
    assign bus.mem_rd_req        = rd_req;
    assign bus.mem_wr_req        = wr_req;
    assign bus.mem_wdata         = evict_q;

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing FSM sitting directly upstream of the direct-mapped `cache_memory` array, between the CPU load/store port and the DDR block interface. Accepts single-word CPU reads/writes and performs a lookup against the array. On a miss it evicts dirty blocks to DDR, refills from DDR, then writes the block back into the array. Policy is write-back, write-allocate, one outstanding request.

## Interface
Parameters:
- `ADDR_WIDTH`, 28: CPU word-address width.
- `DATA_WIDTH`, 32: CPU word width.
- `BLOCK_SIZE`, 256: line width in bits; `WORDS` = `BLOCK_SIZE`/`DATA_WIDTH` = 8, offset = 3 bits.
- `CACHE_SIZE`, 65536: bytes; index = 11 bits, tag = 14 bits.

Ports:
- `clk`, in, 1: single clock; all state updates on posedge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `cpu_addr`, in, `ADDR_WIDTH`: word address as {tag, index, offset}.
- `cpu_rd`, in, 1: read request; sampled only in IDLE.
- `cpu_wr`, in, 1: write request; sampled only in IDLE; wins if both are high.
- `cpu_wdata`, in, `DATA_WIDTH`: store data.
- `cpu_rdata`, out, `DATA_WIDTH`: load data; valid while `cpu_ready`=1, otherwise holds its last value.
- `cpu_ready`, out, 1: one-cycle completion strobe.
- `cpu_busy`, out, 1: high whenever state ≠ IDLE.
- `cache_addr`, out, `ADDR_WIDTH`: address to array; driven from the latched request.
- `cache_data_write`, out, `BLOCK_SIZE`: block to array.
- `cache_dirty_write`, out, 1: dirty bit to array.
- `cache_write_en`, out, 1: array write strobe.
- `cache_data_read`, in, `BLOCK_SIZE`: array block.
- `cache_dirty_read`, in, 1: array dirty bit.
- `cache_hit`, in, 1: array hit.
- `cache_replace_tag`, in, 15: resident tag; only bits [13:0] are used.
- `mem_addr`, out, `ADDR_WIDTH`: block-aligned DDR address; low 3 bits are 0.
- `mem_rd_req`, out, 1: DDR block-read request; level signal.
- `mem_wr_req`, out, 1: DDR block-write request; level signal.
- `mem_wdata`, out, `BLOCK_SIZE`: eviction data.
- `mem_rdata`, in, `BLOCK_SIZE`: fill data; valid with `mem_ack`.
- `mem_ack`, in, 1: one-cycle completion pulse for the pending request.

## Operation
The state register is one of IDLE, LOOKUP, WRITEBACK, FILL, UPDATE.

- **IDLE:** if `cpu_wr`|`cpu_rd`, latch addr, wdata and op (write if `cpu_wr`), then go to LOOKUP. Otherwise stay.
- **LOOKUP:** `cache_addr` = latched address. The array samples it on the intervening negedge, and `cache_hit`/`cache_dirty_read` are evaluated at the closing posedge.
  - Read hit: `cpu_ready`=1 this cycle, `cpu_rdata` = word[offset] of `cache_data_read`; go to IDLE.
  - Write hit: `line_buf` ← `cache_data_read`; go to UPDATE.
  - Miss with `cache_dirty_read`=1: `evict_buf` ← `cache_data_read`, `evict_addr` ← {`cache_replace_tag`[13:0], index, 3'b0}; go to WRITEBACK.
  - Miss, clean: go to FILL.
- **WRITEBACK:** `mem_wr_req`=1, `mem_addr`=`evict_addr`, `mem_wdata`=`evict_buf`. Hold until `mem_ack`, then go to FILL.
- **FILL:** `mem_rd_req`=1, `mem_addr` = {tag, index, 3'b0}. On `mem_ack`, `line_buf` ← `mem_rdata`; go to UPDATE.
- **UPDATE:** `cache_write_en`=1 for exactly one cycle.
  - `cache_data_write` = `line_buf`, with word[offset] replaced by latched wdata if the op is a write.
  - `cache_dirty_write` = op is a write.
  - `cpu_ready`=1; `cpu_rdata` = word[offset] of the written block.
  - Go to IDLE.
- `mem_rd_req` and `mem_wr_req` are never high together.
- `mem_ack` outside WRITEBACK/FILL is ignored.
- Reset: state=IDLE. `cpu_ready`, `cache_write_en`, `mem_rd_req` and `mem_wr_req` = 0. `cpu_rdata`, buffers and latched request = 0. Reset mid-transaction abandons the DDR request; the request drops in the cycle after the reset edge.

## Timing
- Read hit: request sampled at edge N; `cpu_ready` high in cycle N+1. Latency 1, throughput 1 per 2 cycles.
- Write hit: `cpu_ready` and `cache_write_en` high in cycle N+2.
- Clean miss: `cpu_ready` in the cycle after `mem_ack` for the fill.
- Dirty miss: WRITEBACK completes first; FILL is asserted in the cycle after its `mem_ack`.
- `mem_ack` in the same cycle the request is first raised is legal: minimum 1 cycle per DDR phase.
- UPDATE write lands on the negedge inside the UPDATE cycle. A new request accepted the following cycle reads the updated line.

## Structure
- `cache_pkg`: width localparams (offset/index/tag widths, the `log2` function) and the state enum. Shared with `cache_memory`.
- No sub-module. Word select/merge is an indexed part-select inside this block.

## Test plan
- Cold read addr 0x0000010 with DDR returning a block whose word0=0xA5A5A5A5 → FILL, one UPDATE write with dirty=0, `cpu_rdata`=0xA5A5A5A5. A repeat read hits, with `cpu_ready` 1 cycle after the request and no mem request.
- Write 0xDEADBEEF to 0x0000013 after the above → write hit, UPDATE block word3=0xDEADBEEF, dirty=1, no DDR traffic.
- Read 0x0004010 (same index, new tag) → WRITEBACK to `mem_addr` 0x0000010 carrying 0xDEADBEEF in word3, then FILL from 0x0004010.
- Cold write miss to 0x0008005, data 0x12345678 → FILL, then UPDATE with the filled block word5 replaced and dirty=1; no WRITEBACK.
- `rst_n` low for 1 cycle while in WRITEBACK with `mem_ack` withheld → `mem_wr_req` drops, state IDLE, `cpu_ready` stays 0.
- `cpu_rd`=`cpu_wr`=1 in the same cycle → treated as write. `cpu_rd` pulses while busy are ignored: `cpu_ready` count equals accepted requests.
